// File: rtl/lcd_init_seq.sv
// -----------------------------------------------------------------------------
// lcd_init_seq
//
// Sits in front of the LCD PHY instruction port. On start_i it issues the
// HD44780 power-on initialisation sequence (8 commands with the mandated
// power-up and inter-command delays). After the eighth command it becomes a
// combinational pass-through for user instructions. Until then the user
// stream is stalled (usr_ready_o=0), never dropped.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   start_i      single-cycle request to run (or re-run) initialisation
//   usr_instr_i  user instruction {RS, RWB, DB[7:0]}
//   usr_valid_i  user instruction valid
//   usr_ready_o  user instruction accepted (only while init_done_o=1)
//   instr_o      instruction to the PHY
//   valid_o      instruction valid to the PHY
//   ready_i      PHY ready
//   init_busy_o  initialisation in progress
//   init_done_o  initialisation complete, pass-through active
// -----------------------------------------------------------------------------
module lcd_init_seq #(
  parameter int unsigned INSTR_WIDTH       = 10,
  parameter int unsigned WAIT_WIDTH        = 24,
  parameter int unsigned POWERUP_CYCLES    = 1500000,
  parameter int unsigned LONG_WAIT_CYCLES  = 410000,
  parameter int unsigned SHORT_WAIT_CYCLES = 10000,
  parameter logic [7:0]  FUNC_SET          = 8'h38,
  parameter logic [7:0]  ENTRY_MODE        = 8'h06,
  parameter logic [7:0]  DISP_CTRL         = 8'h0C
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [INSTR_WIDTH-1:0] usr_instr_i,
  input  logic                   usr_valid_i,
  output logic                   usr_ready_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   init_busy_o,
  output logic                   init_done_o
);

  localparam longint unsigned CNT_MAX = (64'd1 << WAIT_WIDTH) - 64'd1;

  // Configuration guards: counter must hold every delay, and the
  // instruction format is fixed at {RS, RWB, DB[7:0]}.
  if (INSTR_WIDTH != 10) begin : g_bad_width
    $error("lcd_init_seq: INSTR_WIDTH must be 10");
  end
  if (longint'(POWERUP_CYCLES) > CNT_MAX ||
      longint'(LONG_WAIT_CYCLES) > CNT_MAX ||
      longint'(SHORT_WAIT_CYCLES) > CNT_MAX) begin : g_bad_wait
    $error("lcd_init_seq: a delay parameter exceeds the WAIT_WIDTH counter range");
  end

  localparam logic [WAIT_WIDTH-1:0] PWR_LOAD   = WAIT_WIDTH'(POWERUP_CYCLES);
  localparam logic [WAIT_WIDTH-1:0] LONG_LOAD  = WAIT_WIDTH'(LONG_WAIT_CYCLES);
  localparam logic [WAIT_WIDTH-1:0] SHORT_LOAD = WAIT_WIDTH'(SHORT_WAIT_CYCLES);
  localparam logic [WAIT_WIDTH-1:0] CNT_ONE    = WAIT_WIDTH'(1);

  // Command ROM, step 0 in the least significant byte.
  localparam logic [63:0] ROM_PACKED = {DISP_CTRL, ENTRY_MODE, 8'h01, 8'h08,
                                        FUNC_SET, 8'h30, 8'h30, 8'h30};

  logic [7:0] rom_w [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_rom
    assign rom_w[gi] = ROM_PACKED[gi*8 +: 8];
  end

  typedef enum logic [2:0] {
    IDLE,
    PWR_WAIT,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]            step_q, step_d;

  // Post-step delay: only the three 0x30 wake-up commands need one; the
  // remaining commands rely on the PHY's busy handling via ready_i.
  logic                  step_has_wait;
  logic [WAIT_WIDTH-1:0] step_wait;

  always_comb begin
    step_has_wait = (step_q <= 3'd2);
    step_wait     = (step_q == 3'd0) ? LONG_LOAD : SHORT_LOAD;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  // Outputs decode the registered state only (plus the pass-through path in
  // DONE), so instr_o/valid_o are stable for the whole cycle and hold while
  // the PHY stalls. The delay states last max(N,1) cycles: the counter is
  // loaded with N and the state exits on the cycle it reads 1 or 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    instr_o     = '0;
    valid_o     = 1'b0;
    usr_ready_o = 1'b0;
    init_busy_o = 1'b0;
    init_done_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = PWR_WAIT;
          cnt_d   = PWR_LOAD;
          step_d  = 3'd0;
        end
      end

      PWR_WAIT, WAIT: begin
        init_busy_o = 1'b1;
        if (cnt_q <= CNT_ONE) begin
          state_d = ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ISSUE: begin
        init_busy_o = 1'b1;
        valid_o     = 1'b1;
        instr_o     = {2'b00, rom_w[step_q]};
        if (ready_i) begin
          if (step_q == 3'd7) begin
            state_d = DONE;
          end else begin
            step_d = step_q + 3'd1;
            if (step_has_wait) begin
              state_d = WAIT;
              cnt_d   = step_wait;
            end
          end
        end
      end

      DONE: begin
        init_done_o = 1'b1;
        instr_o     = usr_instr_i;
        valid_o     = usr_valid_i;
        usr_ready_o = ready_i;
        // A user transfer in this same cycle still completes through the
        // pass-through above; the restart takes effect next cycle.
        if (start_i) begin
          state_d = PWR_WAIT;
          cnt_d   = PWR_LOAD;
          step_d  = 3'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_init_seq.sv
module tb_lcd_init_seq;

  localparam int PWR = 20;
  localparam int LW  = 10;
  localparam int SW  = 3;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       start_i = 1'b0;
  logic [9:0] usr_instr_i = '0;
  logic       usr_valid_i = 1'b0;
  logic       ready_i = 1'b0;
  logic       usr_ready_o;
  logic [9:0] instr_o;
  logic       valid_o;
  logic       init_busy_o;
  logic       init_done_o;

  always #5 clk_i = ~clk_i;

  lcd_init_seq #(
    .INSTR_WIDTH      (10),
    .WAIT_WIDTH       (24),
    .POWERUP_CYCLES   (PWR),
    .LONG_WAIT_CYCLES (LW),
    .SHORT_WAIT_CYCLES(SW),
    .FUNC_SET         (8'h38),
    .ENTRY_MODE       (8'h06),
    .DISP_CTRL        (8'h0C)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .usr_instr_i(usr_instr_i),
    .usr_valid_i(usr_valid_i),
    .usr_ready_o(usr_ready_o),
    .instr_o    (instr_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .init_busy_o(init_busy_o),
    .init_done_o(init_done_o)
  );

  // Reference: the HD44780 command list and, for each command, how many
  // cycles after the previous event (start acceptance or previous transfer)
  // its valid must first appear.
  typedef struct {
    logic [9:0] ins;
    int         gap;
  } exp_t;

  logic [7:0] exp_rom [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  int         exp_gap [8] = '{PWR + 1, LW + 1, SW + 1, SW + 1, 1, 1, 1, 1};

  exp_t       init_q [$];
  logic [9:0] usr_q [$];

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 initialising, 2 pass-through.
  int         phase = 0;
  int         cyc = 0;
  int         ref_cyc = 0;
  int         since = 0;
  int         init_cnt = 0;
  bit         pending = 1'b0;
  bit         hold_prev = 1'b0;
  logic [9:0] prev_instr = '0;
  int         nphase = 0;
  exp_t       mon_e;
  logic [9:0] mon_u;
  int         ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing expected=present cyc=%0d", name, cyc);
  endtask

  function automatic void push_init();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.ins = {2'b00, exp_rom[i]};
      e.gap = exp_gap[i];
      init_q.push_back(e);
    end
  endfunction

  // PHY ready driver: 0 tied high, 1 random, 2 held low.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = ($urandom_range(0, 3) != 0);
        default: ready_i = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        cyc++;
        check("busy", 32'(init_busy_o), 32'(phase == 1));
        check("done", 32'(init_done_o), 32'(phase == 2));
        if (phase != 2) check("usr_ready_stall", 32'(usr_ready_o), 32'd0);
        if (phase == 0) begin
          check("idle_valid", 32'(valid_o), 32'd0);
          check("idle_instr", 32'(instr_o), 32'd0);
        end
        if (phase == 2) begin
          check("pass_valid", 32'(valid_o), 32'(usr_valid_i));
          check("pass_ready", 32'(usr_ready_o), 32'(ready_i));
          if (usr_valid_i) check("pass_instr", 32'(instr_o), 32'(usr_instr_i));
        end
        if (hold_prev) begin
          check("hold_valid", 32'(valid_o), 32'd1);
          check("hold_instr", 32'(instr_o), 32'(prev_instr));
        end
        if (phase == 1 && valid_o && !pending) begin
          pending = 1'b1;
          since   = cyc;
        end
        nphase = phase;
        if (valid_o && ready_i) begin
          $display("XFER cyc=%0d instr=%03h mode=%s", cyc, instr_o, (phase == 2) ? "user" : "init");
          if (phase == 2) begin
            if (usr_q.size() == 0) fail_msg("usr_unexpected");
            else begin
              mon_u = usr_q.pop_front();
              check("usr_instr", 32'(instr_o), 32'(mon_u));
            end
          end else if (phase == 1) begin
            if (init_q.size() == 0) fail_msg("init_unexpected");
            else begin
              mon_e = init_q.pop_front();
              check("init_instr", 32'(instr_o), 32'(mon_e.ins));
              check("init_gap", 32'(since - ref_cyc), 32'(mon_e.gap));
            end
            ref_cyc  = cyc;
            pending  = 1'b0;
            init_cnt = init_cnt + 1;
            if (init_cnt == 8) nphase = 2;
          end
        end
        hold_prev  = (phase == 1) && valid_o && !ready_i;
        prev_instr = instr_o;
        if (start_i && (phase == 0 || phase == 2)) begin
          nphase   = 1;
          ref_cyc  = cyc;
          init_cnt = 0;
          pending  = 1'b0;
        end
        phase = nphase;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    if (phase != 1) push_init();
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_phase(input int target);
    int n = 0;
    while (phase != target && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (phase != target) fail_msg("timeout_phase");
  endtask

  task automatic wait_cnt(input int k);
    int n = 0;
    while (init_cnt < k && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (init_cnt < k) fail_msg("timeout_cnt");
  endtask

  task automatic wait_present(input logic [9:0] ins);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(valid_o && instr_o == ins) && n < 5000);
    if (!(valid_o && instr_o == ins)) fail_msg("timeout_present");
  endtask

  task automatic send_user(input logic [9:0] ins);
    int n = 0;
    @(posedge clk_i);
    #1;
    usr_valid_i = 1'b1;
    usr_instr_i = ins;
    usr_q.push_back(ins);
    do begin
      @(negedge clk_i);
      n++;
    end while (!(usr_ready_o && ready_i) && n < 5000);
    if (!(usr_ready_o && ready_i)) fail_msg("timeout_user");
    @(posedge clk_i);
    #1;
    usr_valid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_instr"}, 32'(instr_o), 32'd0);
    check({tag, "_valid"}, 32'(valid_o), 32'd0);
    check({tag, "_usr_ready"}, 32'(usr_ready_o), 32'd0);
    check({tag, "_busy"}, 32'(init_busy_o), 32'd0);
    check({tag, "_done"}, 32'(init_done_o), 32'd0);
  endtask

  initial begin
    // Power-on reset.
    #2 rst_i = 1'b1;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);

    // Baseline run, ready tied high.
    ready_mode = 0;
    pulse_start();
    wait_phase(2);

    // Re-run with ignored starts (PWR_WAIT and ISSUE) plus backpressure on step 3.
    pulse_start();
    repeat (5) @(posedge clk_i);
    pulse_start();
    wait_cnt(3);
    ready_mode = 2;
    wait_present(10'h038);
    pulse_start();
    repeat (3) @(posedge clk_i);
    ready_mode = 0;
    wait_phase(2);

    // User instruction stalled during init, random PHY ready.
    ready_mode = 1;
    pulse_start();
    repeat (4) @(posedge clk_i);
    send_user(10'h241);

    // Re-init collision with a user transfer.
    wait_phase(2);
    ready_mode = 0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    usr_valid_i = 1'b1;
    usr_instr_i = 10'($urandom);
    usr_q.push_back(usr_instr_i);
    start_i = 1'b1;
    push_init();
    @(posedge clk_i);
    #1;
    start_i     = 1'b0;
    usr_valid_i = 1'b0;
    wait_phase(2);

    // Random user traffic in pass-through.
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      send_user(10'($urandom));
    end

    // Reset during the wait after step 1, then rerun from step 0.
    ready_mode = 0;
    pulse_start();
    wait_cnt(2);
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1 check_all_zero("midreset");
    init_q.delete();
    usr_q.delete();
    phase     = 0;
    init_cnt  = 0;
    pending   = 1'b0;
    hold_prev = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (4) @(posedge clk_i);
    pulse_start();
    wait_phase(2);

    // Fully random-ready run.
    ready_mode = 1;
    pulse_start();
    wait_phase(2);
    repeat (3) @(posedge clk_i);

    check("init_q_left", 32'(init_q.size()), 32'd0);
    check("usr_q_left", 32'(usr_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_init_seq.md
Name: lcd_init_seq

Overview:
- Instruction-stream front end that sits directly upstream of the LCD driver PHY instruction port (valid/ready, {RS, RWB, DB[7:0]} format).
- When commanded, it issues the HD44780 power-on initialisation sequence, including the mandated inter-command delays.
- After initialisation it becomes a zero-latency pass-through for user instructions from the register block.
- It blocks the user stream until the LCD is known-initialised.

Parameters:
- INSTR_WIDTH, 10, instruction width {RS, RWB, DB7..DB0}; fixed at 10 for this block.
- WAIT_WIDTH, 24, width of the delay counter.
- POWERUP_CYCLES, 1500000, cycles waited before the first command (15 ms at 100 MHz).
- LONG_WAIT_CYCLES, 410000, cycles waited after the 1st 0x30 command (4.1 ms).
- SHORT_WAIT_CYCLES, 10000, cycles waited after the 2nd and 3rd 0x30 commands (100 us).
- FUNC_SET, 8'h38, function-set byte: 8-bit bus, 2 lines, 5x8 font.
- ENTRY_MODE, 8'h06, entry-mode byte.
- DISP_CTRL, 8'h0C, final display-control byte.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous active-high reset.
- start_i, in, 1, single-cycle request to run (or re-run) initialisation.
- usr_instr_i, in, INSTR_WIDTH, user instruction from the register block.
- usr_valid_i, in, 1, user instruction valid.
- usr_ready_o, out, 1, user instruction accepted.
- instr_o, out, INSTR_WIDTH, instruction to the PHY.
- valid_o, out, 1, instruction valid to the PHY.
- ready_i, in, 1, PHY ready.
- init_busy_o, out, 1, initialisation in progress.
- init_done_o, out, 1, initialisation completed; pass-through is active.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-sequence or mid-handshake):
  - State is IDLE.
  - instr_o = 10'h000; valid_o, usr_ready_o, init_busy_o and init_done_o are 0.
  - Counter and step index are 0.
- ROM, steps 0..7, all with RS=0 and RWB=0: 0x30, 0x30, 0x30, FUNC_SET, 0x08, 0x01, ENTRY_MODE, DISP_CTRL.
- Post-step waits:
  - Step 0: LONG_WAIT_CYCLES.
  - Steps 1 and 2: SHORT_WAIT_CYCLES.
  - Steps 3..7: no wait; the PHY enforces busy timing through ready_i.
- Handshake: a transfer occurs on a cycle where valid_o && ready_i.
  - While valid_o=1 and no transfer has occurred, instr_o is held stable.
  - valid_o never deasserts before its transfer.
- FSM states: IDLE, PWR_WAIT, ISSUE, WAIT, DONE.
- IDLE:
  - All handshake outputs are 0 and usr_ready_o=0.
  - start_i=1 -> PWR_WAIT next cycle; counter loads POWERUP_CYCLES; step=0.
- PWR_WAIT:
  - init_busy_o=1.
  - Lasts exactly max(POWERUP_CYCLES,1) cycles, then -> ISSUE.
- ISSUE:
  - valid_o=1 (registered); instr_o = {2'b00, ROM[step]}.
  - On transfer: if the step has a wait -> WAIT, counter loaded, step+1.
  - On transfer with no wait and step<7 -> ISSUE, step+1; valid_o stays 1 with the new instruction on the next cycle.
  - On transfer at step==7 -> DONE.
- WAIT:
  - valid_o=0.
  - Lasts exactly max(N,1) cycles, then -> ISSUE.
- DONE:
  - init_done_o=1, init_busy_o=0.
  - Combinational pass-through: instr_o=usr_instr_i, valid_o=usr_valid_i, usr_ready_o=ready_i.
- Outside DONE: usr_ready_o=0; user requests stall and are never dropped.
- start_i timing:
  - Ignored in PWR_WAIT, ISSUE and WAIT.
  - In DONE, start_i -> PWR_WAIT next cycle.
  - A user transfer that completes in the same cycle as start_i in DONE still counts as transferred.
  - From the next cycle on, usr_ready_o=0 and init_done_o=0.
- Counter: down-counter of WAIT_WIDTH bits. Parameter values that exceed 2^WAIT_WIDTH-1 are a configuration error; flag with an elaboration assertion.
- Exclusivity: init_busy_o and init_done_o are never both 1.
- Transfer count: exactly 8 PHY transfers per initialisation run.

Test Plan (POWERUP_CYCLES=20, LONG_WAIT_CYCLES=10, SHORT_WAIT_CYCLES=3):
- Reset mid-operation: assert rst_i during WAIT after step 1 -> all outputs 0 in the same cycle; after release the block sits in IDLE, and start_i reruns from step 0.
- Full initialisation with ready_i tied to 1: pulse start_i at cycle 0 ->
  - valid_o first rises at cycle 21 with instr_o=10'h030.
  - Transfer gaps of 10, 3 and 3 cycles after the three 0x30 transfers.
  - Then 0x038, 0x008, 0x001, 0x006, 0x00C on consecutive cycles.
  - init_done_o=1 the cycle after the 0x00C transfer.
- PHY backpressure: hold ready_i=0 for 5 cycles while step 3 is presented -> instr_o stays 10'h038 and valid_o stays 1 throughout; exactly one transfer occurs; the next instruction is 10'h008.
- User stall: usr_valid_i=1 with usr_instr_i=10'h241 during initialisation -> usr_ready_o=0 throughout; the instruction passes on the first DONE cycle that has ready_i=1; instr_o=10'h241 in that cycle.
- Re-init collision: in DONE, drive start_i together with a user transfer -> that user transfer completes; the next cycle has init_busy_o=1 and usr_ready_o=0; the full 8-command sequence repeats.
- Ignored start: pulse start_i during PWR_WAIT and during ISSUE -> no restart; the sequence timing is identical to the baseline run.
